// File: rtl/menu_state_fsm.sv
// menu_state_fsm
//   Game-flow sequencer sitting in front of the menu overlay renderer. It turns
//   the raw mode/start buttons into the menu/countdown overlay controls, and then
//   releases the game core. It goes back to the menu when the core reports
//   game_over.
//
// Ports
//   pixel_clk         in   1  only clock
//   reset             in   1  asynchronous, active-low
//   btn_mode          in   1  raw mode button, asynchronous, active-high
//   btn_start         in   1  raw start button, asynchronous, active-high
//   game_over         in   1  level from the game core; looked at in PLAY only
//   menu_active       out  1  high in MENU
//   countdown_active  out  1  high in COUNTDOWN
//   countdown_value   out  8  COUNT_START..0 while counting down
//   game_mode_1p      out  1  1 = one player, 0 = two players
//   game_active       out  1  high in PLAY
//   game_start_pulse  out  1  single-cycle strobe on COUNTDOWN -> PLAY
//
// Build option
//   BTN_DEBOUNCE_EN   Defining this macro adds a per-button debounce counter
//                     (parameter DEBOUNCE_CYCLES). When the macro is undefined,
//                     the edge detector uses the synchroniser output directly.
//
// State table
//   S_MENU      | menu shown; mode press toggles game_mode_1p, start press begins countdown
//   S_COUNTDOWN | countdown_value steps COUNT_START..0, each held TICK_CYCLES cycles
//   S_PLAY      | game core running until game_over

module menu_state_fsm #(
    parameter int unsigned TICK_CYCLES     = 25_000_000,
    parameter int unsigned COUNT_START     = 3
`ifdef BTN_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 250_000
`endif
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       game_over,
    output logic       menu_active,
    output logic       countdown_active,
    output logic [7:0] countdown_value,
    output logic       game_mode_1p,
    output logic       game_active,
    output logic       game_start_pulse
);

    localparam int unsigned TW = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [7:0]    CNT_INIT  = 8'(COUNT_START);

    typedef enum logic [1:0] {
        S_MENU      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_PLAY      = 2'd2
    } state_t;

    // Bit 0 = mode button, bit 1 = start button.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] btn_lvl;
    logic [1:0] prev_q;
    logic [1:0] press_q;

    assign btn_raw = {btn_start, btn_mode};

    // The synchroniser and edge flops reset high. This way, a button that is held
    // through reset must be released and pressed again before it counts.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    db_q;
    logic [DW-1:0] db_cnt_q [2];

    // The debounced level follows the synchronised level only after the two
    // have differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            db_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign btn_lvl = db_q;
`else
    assign btn_lvl = sync2_q;
`endif

    // The press strobe is registered. A raw rise therefore reaches the FSM on the
    // third edge after the rise, and the outputs react on the fourth edge.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= 2'b11;
            press_q <= 2'b00;
        end else begin
            prev_q  <= btn_lvl;
            press_q <= btn_lvl & ~prev_q;
        end
    end

    logic mode_press;
    logic start_press;

    assign mode_press  = press_q[0];
    assign start_press = press_q[1];

    state_t        state_q;
    logic [TW-1:0] tick_q;

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_MENU;
            tick_q           <= '0;
            menu_active      <= 1'b1;
            countdown_active <= 1'b0;
            countdown_value  <= 8'd0;
            game_mode_1p     <= 1'b1;
            game_active      <= 1'b0;
            game_start_pulse <= 1'b0;
        end else begin
            game_start_pulse <= 1'b0;
            unique case (state_q)
                S_MENU: begin
                    tick_q <= '0;
                    // A start press wins over a mode press in the same cycle.
                    if (start_press) begin
                        state_q          <= S_COUNTDOWN;
                        menu_active      <= 1'b0;
                        countdown_active <= 1'b1;
                        countdown_value  <= CNT_INIT;
                    end else if (mode_press) begin
                        game_mode_1p <= ~game_mode_1p;
                    end
                end

                S_COUNTDOWN: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (countdown_value != 8'd0) begin
                            countdown_value <= countdown_value - 8'd1;
                        end else begin
                            state_q          <= S_PLAY;
                            countdown_active <= 1'b0;
                            game_active      <= 1'b1;
                            game_start_pulse <= 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end

                S_PLAY: begin
                    tick_q <= '0;
                    if (game_over) begin
                        state_q         <= S_MENU;
                        game_active     <= 1'b0;
                        menu_active     <= 1'b1;
                        countdown_value <= 8'd0;
                    end
                end

                default: begin
                    state_q          <= S_MENU;
                    tick_q           <= '0;
                    menu_active      <= 1'b1;
                    countdown_active <= 1'b0;
                    countdown_value  <= 8'd0;
                    game_active      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_menu_state_fsm.sv
module tb_menu_state_fsm;

    localparam int TICK = 4;
    localparam int CS   = 3;
`ifdef BTN_DEBOUNCE_EN
    localparam int DEB  = 8;
    localparam int LAT  = DEB + 3;
    localparam int HOLD = 10;
    localparam int GAP  = DEB + 4;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 1;
    localparam int GAP  = 3;
`endif

    logic       pixel_clk;
    logic       reset;
    logic       btn_mode;
    logic       btn_start;
    logic       game_over;
    logic       menu_active;
    logic       countdown_active;
    logic [7:0] countdown_value;
    logic       game_mode_1p;
    logic       game_active;
    logic       game_start_pulse;

    int checks = 0;
    int errors = 0;

    menu_state_fsm #(
        .TICK_CYCLES     (TICK),
        .COUNT_START     (CS)
`ifdef BTN_DEBOUNCE_EN
        ,
        .DEBOUNCE_CYCLES (DEB)
`endif
    ) dut (
        .pixel_clk        (pixel_clk),
        .reset            (reset),
        .btn_mode         (btn_mode),
        .btn_start        (btn_start),
        .game_over        (game_over),
        .menu_active      (menu_active),
        .countdown_active (countdown_active),
        .countdown_value  (countdown_value),
        .game_mode_1p     (game_mode_1p),
        .game_active      (game_active),
        .game_start_pulse (game_start_pulse)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic step(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    // which: 0 = mode, 1 = start. Returns on the negedge just after the edge where
    // the outputs react to the press.
    task automatic press(input bit which);
        step(GAP);
        if (which) btn_start = 1'b1; else btn_mode = 1'b1;
        step(HOLD);
        if (which) btn_start = 1'b0; else btn_mode = 1'b0;
        step(LAT + 1 - HOLD);
    endtask

    task automatic test_reset();
        reset = 1'b0; btn_mode = 1'b0; btn_start = 1'b0; game_over = 1'b0;
        step(3);
        reset = 1'b1;
        step(10);
        checks++;
        if ({menu_active, countdown_active, countdown_value, game_mode_1p, game_active, game_start_pulse}
            !== {1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got menu=%0b cd=%0b val=%0d 1p=%0b ga=%0b sp=%0b expected 1 0 0 1 0 0",
                     menu_active, countdown_active, countdown_value, game_mode_1p, game_active, game_start_pulse);
        end
    endtask

    task automatic test_mode_toggle();
        step(GAP);
        btn_mode = 1'b1;
        step(HOLD);
        btn_mode = 1'b0;
        step(LAT - HOLD);
        checks++;
        if (game_mode_1p !== 1'b1) begin
            errors++; $display("FAIL mode_early: got %0b expected 1", game_mode_1p);
        end
        step(1);
        checks++;
        if (game_mode_1p !== 1'b0) begin
            errors++; $display("FAIL mode_toggle1: got %0b expected 0", game_mode_1p);
        end
        press(1'b0);
        checks++;
        if (game_mode_1p !== 1'b1) begin
            errors++; $display("FAIL mode_toggle2: got %0b expected 1", game_mode_1p);
        end
    endtask

    task automatic test_countdown();
        press(1'b1);
        for (int v = CS; v >= 0; v--) begin
            for (int k = 0; k < TICK; k++) begin
                checks++;
                if (countdown_active !== 1'b1 || menu_active !== 1'b0 || game_active !== 1'b0
                    || countdown_value !== 8'(v)) begin
                    errors++;
                    $display("FAIL countdown_v%0d_c%0d: got cd=%0b menu=%0b ga=%0b val=%0d expected 1 0 0 %0d",
                             v, k, countdown_active, menu_active, game_active, countdown_value, v);
                end
                step(1);
            end
        end
        checks++;
        if ({game_active, game_start_pulse, countdown_active, menu_active, countdown_value}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL play_entry: got ga=%0b sp=%0b cd=%0b menu=%0b val=%0d expected 1 1 0 0 0",
                     game_active, game_start_pulse, countdown_active, menu_active, countdown_value);
        end
        step(1);
        checks++;
        if (game_start_pulse !== 1'b0 || game_active !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse_width: got sp=%0b ga=%0b expected 0 1", game_start_pulse, game_active);
        end
    endtask

    task automatic test_play_ignores_buttons();
        press(1'b0);
        press(1'b1);
        step(3);
        checks++;
        if (game_active !== 1'b1 || menu_active !== 1'b0 || game_mode_1p !== 1'b1) begin
            errors++;
            $display("FAIL play_ignore: got ga=%0b menu=%0b 1p=%0b expected 1 0 1",
                     game_active, menu_active, game_mode_1p);
        end
    endtask

    task automatic test_game_over();
        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        checks++;
        if ({menu_active, game_active, countdown_active, countdown_value, game_mode_1p}
            !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL game_over: got menu=%0b ga=%0b cd=%0b val=%0d 1p=%0b expected 1 0 0 0 1",
                     menu_active, game_active, countdown_active, countdown_value, game_mode_1p);
        end
        step(3);
        checks++;
        if (menu_active !== 1'b1) begin
            errors++; $display("FAIL menu_stays: got %0b expected 1", menu_active);
        end
    endtask

    task automatic test_mode_start_same();
        press(1'b0);
        checks++;
        if (game_mode_1p !== 1'b0) begin
            errors++; $display("FAIL mode_to_2p: got %0b expected 0", game_mode_1p);
        end
        step(GAP);
        btn_mode = 1'b1; btn_start = 1'b1;
        step(HOLD);
        btn_mode = 1'b0; btn_start = 1'b0;
        step(LAT + 1 - HOLD);
        checks++;
        if (countdown_active !== 1'b1 || game_mode_1p !== 1'b0 || countdown_value !== 8'd3) begin
            errors++;
            $display("FAIL same_cycle: got cd=%0b 1p=%0b val=%0d expected 1 0 3",
                     countdown_active, game_mode_1p, countdown_value);
        end
        press(1'b0);
        checks++;
        if (game_mode_1p !== 1'b0) begin
            errors++; $display("FAIL cd_ignore_mode: got %0b expected 0", game_mode_1p);
        end
        step(20);
        checks++;
        if (game_active !== 1'b1 || game_mode_1p !== 1'b0) begin
            errors++;
            $display("FAIL play_after_same: got ga=%0b 1p=%0b expected 1 0", game_active, game_mode_1p);
        end
    endtask

    task automatic test_reset_mid_countdown();
        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        press(1'b1);
        step(TICK);
        checks++;
        if (countdown_value !== 8'd2) begin
            errors++; $display("FAIL reach_val2: got %0d expected 2", countdown_value);
        end
        btn_start = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if ({menu_active, countdown_active, countdown_value, game_mode_1p, game_active}
            !== {1'b1, 1'b0, 8'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got menu=%0b cd=%0b val=%0d 1p=%0b ga=%0b expected 1 0 0 1 0",
                     menu_active, countdown_active, countdown_value, game_mode_1p, game_active);
        end
        step(2);
        reset = 1'b1;
        step(LAT + 6);
        checks++;
        if (menu_active !== 1'b1 || countdown_active !== 1'b0) begin
            errors++;
            $display("FAIL held_start: got menu=%0b cd=%0b expected 1 0", menu_active, countdown_active);
        end
        btn_start = 1'b0;
        press(1'b1);
        checks++;
        if (countdown_active !== 1'b1 || countdown_value !== 8'd3) begin
            errors++;
            $display("FAIL repress_start: got cd=%0b val=%0d expected 1 3", countdown_active, countdown_value);
        end
    endtask

    task automatic test_bounce();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(GAP);
`ifdef BTN_DEBOUNCE_EN
        btn_mode = 1'b1;
        step(5);
        btn_mode = 1'b0;
        step(20);
        checks++;
        if (game_mode_1p !== 1'b1) begin
            errors++; $display("FAIL glitch_filtered: got %0b expected 1", game_mode_1p);
        end
        btn_mode = 1'b1;
        step(10);
        btn_mode = 1'b0;
        step(20);
        checks++;
        if (game_mode_1p !== 1'b0) begin
            errors++; $display("FAIL debounced_press: got %0b expected 0", game_mode_1p);
        end
`else
        for (int i = 0; i < 3; i++) begin
            btn_mode = 1'b1;
            step(1);
            btn_mode = 1'b0;
            step(2);
        end
        step(6);
        checks++;
        if (game_mode_1p !== 1'b0) begin
            errors++; $display("FAIL bounce_presses: got %0b expected 0", game_mode_1p);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mode_toggle();
        test_countdown();
        test_play_ignores_buttons();
        test_game_over();
        test_mode_start_same();
        test_reset_mid_countdown();
        test_bounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
